// File: rtl/fuzz_result_logger.sv
// fuzz_result_logger
// Snoops the fuzzer-to-IP Wishbone bus plus the fuzzer's anomaly outputs and
// builds one result record per fuzz round. Records go into a first-word-fall-
// through FIFO for host readout. Round, anomaly and drop counters are kept
// alongside, and halt_fuzz latches once the anomaly count hits a threshold.

module fuzz_result_logger #(
   parameter int LOG_DEPTH      = 16,
   parameter int HALT_THRESHOLD = 4,
   parameter int LAT_WIDTH      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 log_all,
   input  logic [31:0]          wb_addr,
   input  logic [31:0]          wb_data,
   input  logic                 wb_stb,
   input  logic                 wb_cyc,
   input  logic                 wb_ack,
   input  logic                 wb_err,
   input  logic [31:0]          wb_data_o,
   input  logic                 crash_detected,
   input  logic                 hang_detected,
   input  logic                 overflow_detected,
   input  logic                 round_done,
   output logic                 rec_valid,
   input  logic                 rec_ready,
   output logic [31:0]          rec_addr,
   output logic [31:0]          rec_wdata,
   output logic [31:0]          rec_rdata,
   output logic [4:0]           rec_flags,
   output logic [LAT_WIDTH-1:0] rec_latency,
   output logic [15:0]          rec_round,
   output logic [31:0]          round_count,
   output logic [15:0]          anomaly_count,
   output logic [15:0]          drop_count,
   output logic                 halt_fuzz
);

   localparam int PTR_W = $clog2(LOG_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0]          addr;
      logic [31:0]          wdata;
      logic [31:0]          rdata;
      logic [4:0]           flags;
      logic [LAT_WIDTH-1:0] lat;
      logic [15:0]          round;
   } rec_t;

   // Saturating increment of the bus-latency counter.
   function automatic logic [LAT_WIDTH-1:0] lat_sat_inc(input logic [LAT_WIDTH-1:0] v);
      return (&v) ? v : v + LAT_WIDTH'(1);
   endfunction

   // Saturating increment of the 16-bit status counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   state_t               state;
   state_t               state_next;

   logic [31:0]          sh_addr;
   logic [31:0]          sh_wdata;
   logic [31:0]          sh_rdata;
   logic                 sh_err;
   logic [LAT_WIDTH-1:0] lat_cnt;
   logic                 stk_crash;
   logic                 stk_hang;
   logic                 stk_ovf;

   rec_t                 mem [LOG_DEPTH];
   logic [PTR_W-1:0]     wptr;
   logic [PTR_W-1:0]     rptr;
   logic [CNT_W-1:0]     count;

   rec_t                 new_rec;
   rec_t                 head;
   logic                 anomalous;
   logic                 push_req;
   logic                 push_ok;
   logic                 pop;
   logic                 full;
   logic                 drop;

   // FSM state register; clear restarts the round tracking as well.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: only the first transaction of a round is tracked, and the
   // end of a round always returns to IDLE regardless of bus progress.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (wb_cyc && wb_stb) state_next = BUS;
         BUS:     if (wb_ack || wb_err) state_next = RESP;
         RESP:    state_next = RESP;
         default: state_next = IDLE;
      endcase
      if (round_done) begin
         state_next = IDLE;
      end
   end

   // Shadow capture of the round's transaction, latency count and sticky
   // anomaly flags; everything is wiped once the round's record is formed.
   always_ff @(posedge clk) begin
      if (rst || clear || round_done) begin
         sh_addr   <= '0;
         sh_wdata  <= '0;
         sh_rdata  <= '0;
         sh_err    <= 1'b0;
         lat_cnt   <= '0;
         stk_crash <= 1'b0;
         stk_hang  <= 1'b0;
         stk_ovf   <= 1'b0;
      end else begin
         stk_crash <= stk_crash | crash_detected;
         stk_hang  <= stk_hang  | hang_detected;
         stk_ovf   <= stk_ovf   | overflow_detected;
         unique case (state)
            IDLE: begin
               if (wb_cyc && wb_stb) begin
                  sh_addr  <= wb_addr;
                  sh_wdata <= wb_data;
                  lat_cnt  <= '0;
               end
            end
            BUS: begin
               lat_cnt <= lat_sat_inc(lat_cnt);
               if (wb_ack || wb_err) begin
                  sh_rdata <= wb_data_o;
                  sh_err   <= wb_err;
               end
            end
            default: ;
         endcase
      end
   end

   // Record assembled from the shadows plus this cycle's flag inputs, so a
   // flag pulse coinciding with round_done is still captured. In BUS the
   // latency includes the increment of the closing edge, matching the value
   // that an ack on that same edge would have latched.
   always_comb begin
      new_rec       = '0;
      new_rec.round = round_count[15:0];
      new_rec.flags = {state != RESP,
                       (state == RESP) && sh_err,
                       stk_ovf   | overflow_detected,
                       stk_hang  | hang_detected,
                       stk_crash | crash_detected};
      unique case (state)
         BUS: begin
            new_rec.addr  = sh_addr;
            new_rec.wdata = sh_wdata;
            new_rec.lat   = lat_sat_inc(lat_cnt);
         end
         RESP: begin
            new_rec.addr  = sh_addr;
            new_rec.wdata = sh_wdata;
            new_rec.rdata = sh_rdata;
            new_rec.lat   = lat_cnt;
         end
         default: ;
      endcase
   end

   assign anomalous = |new_rec.flags;
   assign push_req  = round_done && !clear && (log_all || anomalous);
   assign full      = (count == CNT_W'(LOG_DEPTH));
   assign pop       = rec_valid && rec_ready;
   assign push_ok   = push_req && (!full || pop);
   assign drop      = push_req && full && !pop;

   // FIFO storage; contents are only meaningful below the occupancy count.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wptr] <= new_rec;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + PTR_W'(1);
         if (pop)     rptr <= rptr + PTR_W'(1);
         unique case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Round, anomaly and drop counters plus the latched halt request.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         round_count   <= '0;
         anomaly_count <= '0;
         drop_count    <= '0;
         halt_fuzz     <= 1'b0;
      end else begin
         if (round_done) begin
            round_count <= round_count + 32'd1;
            if (anomalous) anomaly_count <= sat_inc16(anomaly_count);
         end
         if (drop) drop_count <= sat_inc16(drop_count);
         if (HALT_THRESHOLD != 0 && anomaly_count >= 16'(HALT_THRESHOLD)) begin
            halt_fuzz <= 1'b1;
         end
      end
   end

   // Head of the FIFO presented directly; outputs read as zero when empty.
   assign head        = mem[rptr];
   assign rec_valid   = (count != '0);
   assign rec_addr    = rec_valid ? head.addr  : '0;
   assign rec_wdata   = rec_valid ? head.wdata : '0;
   assign rec_rdata   = rec_valid ? head.rdata : '0;
   assign rec_flags   = rec_valid ? head.flags : '0;
   assign rec_latency = rec_valid ? head.lat   : '0;
   assign rec_round   = rec_valid ? head.round : '0;

endmodule
